// File: rtl/cv32e40p_alu_voter.sv
// N-way word-level majority voter with per-replica health tracking for redundant ALUs.
// Optional macro CV32E40P_ALU_VOTER_FAULT_INJ_EN adds inj_mask_i to flip result bit 0 per replica.
module cv32e40p_alu_voter #(
    parameter int NUM_REPLICAS = 3,
    parameter int WIDTH        = 32,
    parameter int FAIL_THRESH  = 4,
    parameter int TIMEOUT      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  logic [NUM_REPLICAS*WIDTH-1:0] result_i,
    input  logic [NUM_REPLICAS-1:0]       cmp_i,
    input  logic [NUM_REPLICAS-1:0]       ready_i,
`ifdef CV32E40P_ALU_VOTER_FAULT_INJ_EN
    input  logic [NUM_REPLICAS-1:0]       inj_mask_i,
`endif
    output logic                          vote_ready_o,
    output logic [WIDTH-1:0]              result_o,
    output logic                          cmp_o,
    output logic                          valid_o,
    input  logic                          ex_ready_i,
    output logic                          err_corrected_o,
    output logic                          err_uncorrectable_o,
    output logic [NUM_REPLICAS-1:0]       replica_failed_o,
    output logic                          degraded_o,
    output logic [15:0]                   err_cnt_o,
    input  logic                          clr_i
);

    localparam int PCW  = $clog2(NUM_REPLICAS + 1);
    localparam int CW   = $clog2(FAIL_THRESH + 1);
    localparam int IDXW = $clog2(NUM_REPLICAS);
    localparam logic [CW-1:0] THRESH_C  = CW'(FAIL_THRESH);
    localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

    typedef logic [WIDTH:0] word_t;
    typedef enum logic [1:0] {ST_HEALTHY, ST_SUSPECT, ST_FAILED} health_t;

    // registered state
    logic [WIDTH-1:0]        r_result;
    logic                    r_cmp;
    logic                    r_valid;
    logic                    r_corr;
    logic                    r_unc;
    logic [NUM_REPLICAS-1:0] r_failed;
    logic [15:0]             r_err;
    logic [7:0]              r_wait;
    logic [CW-1:0]           r_cnt [NUM_REPLICAS];

    // combinational datapath
    word_t                   w_word      [NUM_REPLICAS];
    logic [PCW-1:0]          w_match_cnt [NUM_REPLICAS];
    logic [CW-1:0]           w_cnt_next  [NUM_REPLICAS];
    health_t                 w_state     [NUM_REPLICAS];
    logic [NUM_REPLICAS-1:0] w_healthy;
    logic [NUM_REPLICAS-1:0] w_ready_set;
    logic [NUM_REPLICAS-1:0] w_is_winner;
    logic [NUM_REPLICAS-1:0] w_agree;
    logic [NUM_REPLICAS-1:0] w_disagree;
    logic [NUM_REPLICAS-1:0] w_fail_req;
    logic [NUM_REPLICAS-1:0] w_failed_next;
    logic [NUM_REPLICAS-1:0] w_failed_apply;
    logic [PCW-1:0]          w_h_cnt;
    logic [IDXW-1:0]         w_win_idx;
    logic [IDXW-1:0]         w_first_idx;
    logic [IDXW-1:0]         w_sel_idx;
    word_t                   w_sel_word;
    logic                    w_have_winner;
    logic                    w_ready_any;
    logic                    w_vote_ready;
    logic                    w_vote;
    logic                    w_corr;
    logic                    w_unc;

    assign w_healthy    = ~r_failed;
    assign w_ready_set  = w_healthy & ready_i;
    assign w_ready_any  = |w_ready_set;
    assign w_vote_ready = !r_valid || ex_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REPLICAS; gi++) begin : g_rep
            logic [WIDTH-1:0] w_res_k;
`ifdef CV32E40P_ALU_VOTER_FAULT_INJ_EN
            assign w_res_k = result_i[gi*WIDTH +: WIDTH] ^ WIDTH'(inj_mask_i[gi]);
`else
            assign w_res_k = result_i[gi*WIDTH +: WIDTH];
`endif
            assign w_word[gi]      = {cmp_i[gi], w_res_k};
            // strict majority of the healthy set, not just of the replicas that answered
            assign w_is_winner[gi] = w_ready_set[gi] && (w_match_cnt[gi] > (w_h_cnt >> 1));
            assign w_agree[gi]     = w_ready_set[gi] && (w_word[gi] == w_sel_word);
        end
    endgenerate

    always_comb begin
        w_h_cnt = '0;
        for (int k = 0; k < NUM_REPLICAS; k++) begin
            w_h_cnt = w_h_cnt + PCW'(w_healthy[k]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            w_match_cnt[i] = '0;
            for (int j = 0; j < NUM_REPLICAS; j++) begin
                if (w_ready_set[j] && (w_word[j] == w_word[i])) begin
                    w_match_cnt[i] = w_match_cnt[i] + PCW'(1);
                end
            end
        end
    end

    // descending scan leaves the lowest index in each selector
    always_comb begin
        w_have_winner = 1'b0;
        w_win_idx     = '0;
        w_first_idx   = '0;
        for (int k = NUM_REPLICAS - 1; k >= 0; k--) begin
            if (w_is_winner[k]) begin
                w_have_winner = 1'b1;
                w_win_idx     = IDXW'(k);
            end
            if (w_ready_set[k]) begin
                w_first_idx = IDXW'(k);
            end
        end
        w_sel_idx  = w_have_winner ? w_win_idx : w_first_idx;
        w_sel_word = w_word[w_sel_idx];
    end

    assign w_disagree = w_healthy & ~w_agree;
    assign w_vote     = valid_i && w_vote_ready && w_ready_any &&
                        ((w_ready_set == w_healthy) || (r_wait >= TIMEOUT_C));
    assign w_corr     = w_vote && w_have_winner && (|w_disagree);
    assign w_unc      = w_vote && !w_have_winner;

    always_comb begin
        for (int k = 0; k < NUM_REPLICAS; k++) begin
            w_state[k]    = r_failed[k] ? ST_FAILED :
                            ((r_cnt[k] == '0) ? ST_HEALTHY : ST_SUSPECT);
            w_cnt_next[k] = r_cnt[k];
            w_fail_req[k] = 1'b0;
            if (w_vote && w_have_winner) begin
                case (w_state[k])
                    ST_HEALTHY, ST_SUSPECT: begin
                        if (w_disagree[k]) begin
                            if (r_cnt[k] != THRESH_C) begin
                                w_cnt_next[k] = r_cnt[k] + CW'(1);
                            end
                            w_fail_req[k] = (w_cnt_next[k] == THRESH_C);
                        end else begin
                            w_cnt_next[k] = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        w_failed_next  = r_failed | w_fail_req;
        // keep at least one replica in service
        w_failed_apply = (&w_failed_next) ? r_failed : w_failed_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_cmp    <= 1'b0;
            r_valid  <= 1'b0;
            r_corr   <= 1'b0;
            r_unc    <= 1'b0;
            r_failed <= '0;
            r_err    <= '0;
            r_wait   <= '0;
            for (int k = 0; k < NUM_REPLICAS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            if (w_vote) begin
                {r_cmp, r_result} <= w_sel_word;
                r_valid           <= 1'b1;
            end else if (ex_ready_i) begin
                r_valid <= 1'b0;
            end
            r_corr <= w_corr;
            r_unc  <= w_unc;
            if (clr_i) begin
                r_failed <= '0;
                r_err    <= '0;
                r_wait   <= '0;
                for (int k = 0; k < NUM_REPLICAS; k++) begin
                    r_cnt[k] <= '0;
                end
            end else begin
                r_failed <= w_failed_apply;
                r_cnt    <= w_cnt_next;
                if ((w_corr || w_unc) && (r_err != 16'hFFFF)) begin
                    r_err <= r_err + 16'd1;
                end
                if (w_vote || !valid_i) begin
                    r_wait <= '0;
                end else if (w_ready_any && (w_ready_set != w_healthy) && (r_wait < TIMEOUT_C)) begin
                    r_wait <= r_wait + 8'd1;
                end
            end
        end
    end

    assign vote_ready_o        = w_vote_ready;
    assign result_o            = r_result;
    assign cmp_o               = r_cmp;
    assign valid_o             = r_valid;
    assign err_corrected_o     = r_corr;
    assign err_uncorrectable_o = r_unc;
    assign replica_failed_o    = r_failed;
    assign degraded_o          = (w_h_cnt < PCW'(2));
    assign err_cnt_o           = r_err;

endmodule
